// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: keypad codes,
// arithmetic-unit opcodes, sequencer states and small key classifiers.
package calc_pkg;

  // Keypad codes; digits occupy 0..9.
  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_MUL = 5'd18;
  localparam logic [4:0] KEY_DIV = 5'd19;
  localparam logic [4:0] KEY_SHL = 5'd20;
  localparam logic [4:0] KEY_SHR = 5'd21;
  localparam logic [4:0] KEY_SRA = 5'd22;
  localparam logic [4:0] KEY_EQ  = 5'd23;
  localparam logic [4:0] KEY_CLR = 5'd24;

  // Arithmetic-unit opcodes.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_ENTRY_B = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } calc_state_e;

  function automatic logic is_digit(input logic [4:0] k);
    return k <= 5'd9;
  endfunction

  function automatic logic is_oper(input logic [4:0] k);
    return (k >= KEY_ADD) && (k <= KEY_SRA);
  endfunction

  // Operator keys 16..22 map onto opcodes 0..6 through their low bits.
  function automatic logic [2:0] key_to_op(input logic [4:0] k);
    return k[2:0];
  endfunction

endpackage

// File: rtl/calc_dec_accum.sv
// Decimal digit accumulator: acc*10 + digit built from shifts and adds,
// evaluated four bits wider than the operand so overflow is visible.
module calc_dec_accum #(
  parameter int N = 32
) (
  input  logic [N-1:0] acc,
  input  logic [3:0]   digit,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic [N+3:0] wide;

  // acc*10 = acc*8 + acc*2, plus the new digit
  always_comb begin
    wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{N{1'b0}}, digit};
  end

  assign sum = wide[N-1:0];
  assign ovf = |wide[N+3:N];

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: turns accepted keypad codes into operand-bus
// writes, load strobes, opcode and clear for the arithmetic unit, waits a
// programmable settle time before capturing the result, and supports
// chaining a new operation onto the last result.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int N             = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         KeyValid,
  input  logic [4:0]   KeyCode,
  output logic         KeyReady,
  input  logic [N-1:0] Result,
  output logic [N-1:0] Operand,
  output logic         LoadA,
  output logic         LoadB,
  output logic         LoadR,
  output logic [2:0]   Op,
  output logic         AuClear,
  output logic [N-1:0] Display,
  output logic         Error,
  output logic [2:0]   dbg_state
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  calc_state_e  state_q, state_d;
  logic [N-1:0] entry_q, entry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] operand_q, operand_d;
  logic         load_a_q, load_a_d;
  logic         load_b_q, load_b_d;
  logic         load_r_q, load_r_d;
  logic         au_clear_q, au_clear_d;
  logic [N-1:0] display_q, display_d;
  logic         error_q, error_d;

  logic         key_fire;
  logic [N-1:0] acc_sum;
  logic         acc_ovf;

  calc_dec_accum #(.N(N)) u_accum (
    .acc   (entry_q),
    .digit (KeyCode[3:0]),
    .sum   (acc_sum),
    .ovf   (acc_ovf)
  );

  // Key handshake: a key is consumed on a rising edge where KeyValid and
  // KeyReady are both high; the sender must hold KeyCode stable with
  // KeyValid until then. KeyReady is low only while settling/capturing and
  // does not depend on KeyValid.
  assign KeyReady = (state_q == ST_ENTRY_A) || (state_q == ST_ENTRY_B) ||
                    (state_q == ST_SHOW)    || (state_q == ST_ERROR);
  assign key_fire = KeyValid && KeyReady;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    operand_d  = operand_q;
    load_a_d   = 1'b0;
    load_b_d   = 1'b0;
    load_r_d   = 1'b0;
    au_clear_d = 1'b0;
    error_d    = error_q;

    case (state_q)
      ST_ENTRY_A, ST_ENTRY_B, ST_SHOW: begin
        if (key_fire) begin
          if (KeyCode == KEY_CLR) begin
            au_clear_d = 1'b1;
            entry_d    = '0;
            error_d    = 1'b0;
            op_d       = OP_ADD;
            state_d    = ST_ENTRY_A;
          end else if (is_digit(KeyCode)) begin
            if (state_q == ST_SHOW) begin
              // A digit after a result starts a fresh first operand.
              entry_d = N'(KeyCode[3:0]);
              state_d = ST_ENTRY_A;
            end else if (acc_ovf) begin
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              entry_d = acc_sum;
            end
          end else if (is_oper(KeyCode)) begin
            op_d = key_to_op(KeyCode);
            if (state_q == ST_ENTRY_A) begin
              operand_d = entry_q;
              load_a_d  = 1'b1;
              entry_d   = '0;
              state_d   = ST_ENTRY_B;
            end else if (state_q == ST_SHOW) begin
              // Chaining: the last result becomes operand A.
              operand_d = Result;
              load_a_d  = 1'b1;
              entry_d   = '0;
              state_d   = ST_ENTRY_B;
            end
          end else if ((KeyCode == KEY_EQ) && (state_q == ST_ENTRY_B)) begin
            operand_d = entry_q;
            load_b_d  = 1'b1;
            if ((op_q == OP_DIV) && (entry_q == '0)) begin
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        load_r_d = 1'b1;
        state_d  = ST_SHOW;
      end
      ST_ERROR: begin
        // Everything but CLR is consumed and dropped.
        if (key_fire && (KeyCode == KEY_CLR)) begin
          au_clear_d = 1'b1;
          entry_d    = '0;
          error_d    = 1'b0;
          op_d       = OP_ADD;
          state_d    = ST_ENTRY_A;
        end
      end
      default: begin
        state_d = ST_ENTRY_A;
      end
    endcase

    case (state_d)
      ST_ENTRY_A, ST_ENTRY_B: display_d = entry_d;
      ST_SHOW:                display_d = Result;
      ST_ERROR:               display_d = '0;
      default:                display_d = display_q;
    endcase
  end

  // State and output registers; reset also aborts any pending capture
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= ST_ENTRY_A;
      entry_q    <= '0;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      operand_q  <= '0;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      load_r_q   <= 1'b0;
      au_clear_q <= 1'b1;
      display_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      load_a_q   <= load_a_d;
      load_b_q   <= load_b_d;
      load_r_q   <= load_r_d;
      au_clear_q <= au_clear_d;
      display_q  <= display_d;
      error_q    <= error_d;
    end
  end

  assign Operand   = operand_q;
  assign LoadA     = load_a_q;
  assign LoadB     = load_b_q;
  assign LoadR     = load_r_q;
  assign Op        = op_q;
  assign AuClear   = au_clear_q;
  assign Display   = display_q;
  assign Error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed scenarios followed by
// random key streams, checked against a key-level calculator model.
module tb_calc_key_sequencer;

  localparam int S = 4;
  localparam int W = 32;

  localparam logic [4:0] K_ADD = 5'd16;
  localparam logic [4:0] K_SUB = 5'd17;
  localparam logic [4:0] K_MUL = 5'd18;
  localparam logic [4:0] K_DIV = 5'd19;
  localparam logic [4:0] K_EQ  = 5'd23;
  localparam logic [4:0] K_CLR = 5'd24;

  localparam int M_A = 0;  // typing first operand
  localparam int M_B = 1;  // typing second operand
  localparam int M_S = 2;  // showing a result
  localparam int M_E = 3;  // error, waiting for clear

  // ---------------- clock / reset / DUT ----------------
  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         KeyValid = 1'b0;
  logic [4:0]   KeyCode = 5'd0;
  logic         KeyReady;
  logic [W-1:0] Result;
  logic [W-1:0] Operand;
  logic         LoadA, LoadB, LoadR;
  logic [2:0]   Op;
  logic         AuClear;
  logic [W-1:0] Display;
  logic         Error;
  logic [2:0]   dbg_state;

  always #5 Clock = ~Clock;

  calc_key_sequencer #(.N(W), .SETTLE_CYCLES(S)) dut (
    .Clock(Clock), .Reset(Reset), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .KeyReady(KeyReady), .Result(Result), .Operand(Operand), .LoadA(LoadA),
    .LoadB(LoadB), .LoadR(LoadR), .Op(Op), .AuClear(AuClear),
    .Display(Display), .Error(Error), .dbg_state(dbg_state)
  );

  // ---------------- arithmetic unit stand-in ----------------
  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return (b == 0) ? '0 : a / b;
      3'd4: return a << b[4:0];
      3'd5: return a >> b[4:0];
      3'd6: return W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] au_a = '0, au_b = '0, au_r = '0;
  always @(posedge Clock) begin
    if (AuClear) begin
      au_a <= '0; au_b <= '0; au_r <= '0;
    end else begin
      if (LoadA) au_a <= Operand;
      if (LoadB) au_b <= Operand;
      if (LoadR) au_r <= alu(Op, au_a, au_b);
    end
  end
  assign Result = au_r;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: every LoadA/LoadB must match a predicted operand write.
  int cyc = 0, last_lb = 0, last_lr = 0, lr_cnt = 0;
  always @(posedge Clock) begin
    cyc++;
    if (LoadB) last_lb = cyc;
    if (LoadR) begin last_lr = cyc; lr_cnt++; end
    if (LoadA || LoadB) begin
      if (exp_q.size() == 0) check_eq("strobe_unexpected", 1, 0);
      else check_eq("strobe_operand", Operand, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  int           m_mode;
  logic [63:0]  m_entry;
  logic [2:0]   m_op;
  logic         m_err;
  logic [W-1:0] m_a, m_res;
  int           m_lr_exp = 0;
  int           lr_base = 0;
  bit           pending_lr = 0;

  task automatic model_reset();
    m_mode = M_A; m_entry = 0; m_op = 0; m_err = 0; m_a = 0; m_res = 0;
    exp_q.delete();
    pending_lr = 0;
  endtask

  function automatic logic [W-1:0] exp_display();
    case (m_mode)
      M_A, M_B: return m_entry[W-1:0];
      M_S:      return m_res;
      default:  return '0;
    endcase
  endfunction

  task automatic model_step(input logic [4:0] c, output bit la, output bit lb, output bit clr,
                            output bit launch, output logic [W-1:0] opnd);
    logic [63:0] v;
    la = 0; lb = 0; clr = 0; launch = 0; opnd = '0;
    if (c == K_CLR) begin
      clr = 1; m_mode = M_A; m_entry = 0; m_op = 0; m_err = 0; m_res = 0;
    end else if (m_mode == M_E) begin
      // swallowed
    end else if (c <= 5'd9) begin
      if (m_mode == M_S) begin
        m_entry = 64'(c); m_mode = M_A;
      end else begin
        v = m_entry * 10 + 64'(c);
        if (v > 64'hFFFF_FFFF) begin m_err = 1; m_mode = M_E; end
        else m_entry = v;
      end
    end else if (c >= K_ADD && c <= 5'd22) begin
      m_op = 3'(c - K_ADD);
      if (m_mode == M_A || m_mode == M_S) begin
        la = 1;
        opnd = (m_mode == M_A) ? m_entry[W-1:0] : m_res;
        m_a = opnd; m_entry = 0; m_mode = M_B;
      end
    end else if (c == K_EQ && m_mode == M_B) begin
      lb = 1; opnd = m_entry[W-1:0];
      if (m_op == 3'd3 && m_entry == 0) begin
        m_err = 1; m_mode = M_E;
      end else begin
        m_res = alu(m_op, m_a, m_entry[W-1:0]); launch = 1; m_mode = M_S;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int n);
    @(negedge Clock); Reset = 0; KeyValid = 0;
    repeat (n) @(negedge Clock);
    Reset = 1;
    model_reset();
    check_eq("rst_au_clear", AuClear, 1);
    check_eq("rst_load_a", LoadA, 0);
    check_eq("rst_load_b", LoadB, 0);
    check_eq("rst_load_r", LoadR, 0);
    check_eq("rst_op", Op, 0);
    check_eq("rst_error", Error, 0);
    check_eq("rst_key_ready", KeyReady, 1);
    check_eq("rst_display", Display, 0);
    @(negedge Clock);
    check_eq("rst_au_clear_drop", AuClear, 0);
  endtask

  // Entered at a negedge; returns at the negedge after the accepting edge.
  task automatic accept_key(input logic [4:0] code, output int waited);
    waited = 0;
    KeyValid = 1; KeyCode = code;
    while (!KeyReady && waited < 100) begin @(negedge Clock); waited++; end
    if (!KeyReady) begin
      check_eq("key_accept_timeout", 0, 1);
      KeyValid = 0; waited = -1;
      return;
    end
    @(posedge Clock); #1;
    KeyValid = 0; KeyCode = 5'($urandom_range(0, 31));
    @(negedge Clock);
  endtask

  task automatic finish_settle(input bit chk_disp);
    int n = 0;
    while (lr_cnt == lr_base && n < 64) begin @(negedge Clock); n++; end
    check_eq("load_r_seen", 64'(lr_cnt - lr_base), 1);
    check_eq("settle_latency", 64'(last_lr - last_lb), S + 1);
    m_lr_exp++;
    pending_lr = 0;
    if (chk_disp) begin
      repeat (2) @(negedge Clock);
      check_eq("show_display", Display, m_res);
    end
  endtask

  task automatic do_key(input logic [4:0] code, input bit wait_lr, output int waited);
    bit la, lb, clr, launch;
    logic [W-1:0] opnd;
    accept_key(code, waited);
    if (waited < 0) return;
    model_step(code, la, lb, clr, launch, opnd);
    if (la || lb) exp_q.push_back(opnd);
    check_eq("load_a", LoadA, la);
    check_eq("load_b", LoadB, lb);
    check_eq("au_clear", AuClear, clr);
    check_eq("op", Op, m_op);
    check_eq("error", Error, m_err);
    check_eq("key_ready", KeyReady, !launch);
    if (la || lb) check_eq("operand", Operand, opnd);
    if (!launch) check_eq("display", Display, exp_display());
    if (!pending_lr && !launch) check_eq("load_r_count", lr_cnt, m_lr_exp);
    if (launch) begin
      lr_base = lr_cnt; pending_lr = 1;
      if (wait_lr) finish_settle(1);
    end
  endtask

  task automatic keys(input logic [4:0] seq[$]);
    int w;
    foreach (seq[i]) do_key(seq[i], 1, w);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [4:0] code;
    int r;
    apply_reset(3);

    // 12 + 30, then chain * 2
    keys('{5'd1, 5'd2, K_ADD, 5'd3, 5'd0, K_EQ});
    check_eq("t1_result", Display, 42);
    keys('{K_MUL, 5'd2, K_EQ});
    check_eq("t4_result", Display, 84);

    // divide by zero, ignored keys in error, clear
    keys('{K_CLR, 5'd7, K_DIV, 5'd0, K_EQ, K_DIV, 5'd3, K_EQ, K_CLR});

    // largest operand, then one digit too many
    keys('{5'd4, 5'd2, 5'd9, 5'd4, 5'd9, 5'd6, 5'd7, 5'd2, 5'd9, 5'd5});
    check_eq("max_entry", Display, 32'hFFFF_FFFF);
    keys('{5'd1});
    check_eq("ovf_error", Error, 1);
    keys('{5'd5, K_CLR});

    // key held through settle, then operator replacement
    keys('{5'd9, K_SUB, 5'd4});
    do_key(K_EQ, 0, w);
    do_key(5'd7, 1, w);
    check_eq("held_key_wait", w, S + 1);
    finish_settle(0);
    keys('{K_ADD, K_SUB});
    check_eq("op_replaced", Op, 3'b001);

    // reset while settling
    keys('{5'd5});
    do_key(K_EQ, 0, w);
    @(negedge Clock);
    apply_reset(1);
    repeat (S + 3) @(negedge Clock);
    check_eq("no_load_r_after_reset", lr_cnt, lr_base);
    check_eq("reset_display", Display, 0);

    // random key streams
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (m_mode == M_E) code = (r < 40) ? K_CLR : 5'($urandom_range(0, 31));
      else if (r < 55) code = 5'($urandom_range(0, 9));
      else if (r < 75) code = 5'($urandom_range(16, 22));
      else if (r < 88) code = K_EQ;
      else if (r < 91) code = K_CLR;
      else if (r < 95) code = 5'($urandom_range(10, 15));
      else code = 5'($urandom_range(25, 31));
      do_key(code, 1, w);
    end

    repeat (3) @(negedge Clock);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
